// File: rtl/ls244_bus_arbiter.sv
// ls244_bus_arbiter: dead-time bus arbiter driving two ls244 buffer group enables
//   clk    : system clock, all state changes on rising edge
//   reset  : synchronous active-high reset
//   req_a  : requester A (group 1, CPU side) wants the bus, level
//   req_b  : requester B (group 2, DMA side) wants the bus, level
//   gnt_a  : A owns the bus (registered decode)
//   gnt_b  : B owns the bus (registered decode)
//   g1_n   : active-low enable of buffer group 1, ~gnt_a
//   g2_n   : active-low enable of buffer group 2, ~gnt_b
//   busy   : arbiter not idle
module ls244_bus_arbiter #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic g1_n,
    output logic g2_n,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, TURN} state_t;
    localparam logic [7:0] TURN_LD = 8'(TURN_CYC - 1);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic PREEMPT = MAX_HOLD != 0;
    state_t state, state_nx, pick;
    logic [7:0] turn_cnt, turn_nx, hold_cnt, hold_nx;
    logic last, last_nx;
    // last = 1 means B released most recently, so A wins a tie
    assign pick = (req_a & req_b) ? (last ? OWN_A : OWN_B) :
                  req_a ? OWN_A : req_b ? OWN_B : IDLE;
    always_comb begin
        state_nx = state;
        turn_nx = turn_cnt;
        hold_nx = hold_cnt + 8'd1;
        last_nx = last;
        case (state)
            IDLE: state_nx = pick;
            OWN_A: if (!req_a || (PREEMPT && req_b && hold_cnt == HOLD_LIM)) begin
                state_nx = TURN;
                last_nx = 1'b0;
                turn_nx = TURN_LD;
            end
            OWN_B: if (!req_b || (PREEMPT && req_a && hold_cnt == HOLD_LIM)) begin
                state_nx = TURN;
                last_nx = 1'b1;
                turn_nx = TURN_LD;
            end
            default: begin
                turn_nx = turn_cnt - 8'd1;
                if (turn_cnt == 8'd0) state_nx = pick;
            end
        endcase
        // hold counter restarts on every ownership entry
        if (state_nx != state) hold_nx = 8'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            turn_cnt <= 8'd0;
            hold_cnt <= 8'd0;
            last <= 1'b1;
        end else begin
            state <= state_nx;
            turn_cnt <= turn_nx;
            hold_cnt <= hold_nx;
            last <= last_nx;
        end
    end
    assign gnt_a = state == OWN_A;
    assign gnt_b = state == OWN_B;
    assign g1_n = ~gnt_a;
    assign g2_n = ~gnt_b;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_ls244_bus_arbiter.sv
// tb_ls244_bus_arbiter: three parameterisations checked against an owner/dead-time model
module tb_ls244_bus_arbiter;
    logic clk = 1'b0;
    logic reset, req_a, req_b;
    logic ga [3];
    logic gb [3];
    logic e1 [3];
    logic e2 [3];
    logic bz [3];
    int tc [3] = '{2, 2, 3};
    int mh [3] = '{16, 4, 0};
    int own [3];
    int dead [3];
    int held [3];
    int last [3];
    int passed = 0, failed = 0, total = 0, cyc = 0;

    always #5 clk = ~clk;

    ls244_bus_arbiter #(.TURN_CYC(2), .MAX_HOLD(16)) u0 (.clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[0]), .gnt_b(gb[0]), .g1_n(e1[0]), .g2_n(e2[0]), .busy(bz[0]));
    ls244_bus_arbiter #(.TURN_CYC(2), .MAX_HOLD(4)) u1 (.clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[1]), .gnt_b(gb[1]), .g1_n(e1[1]), .g2_n(e2[1]), .busy(bz[1]));
    ls244_bus_arbiter #(.TURN_CYC(3), .MAX_HOLD(0)) u2 (.clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[2]), .gnt_b(gb[2]), .g1_n(e1[2]), .g2_n(e2[2]), .busy(bz[2]));

    // owner: 0 none, 1 A, 2 B; dead: remaining turnaround cycles
    function automatic int pick(int lst);
        if (req_a && req_b) return lst == 1 ? 2 : 1;
        return req_a ? 1 : req_b ? 2 : 0;
    endfunction

    task automatic step_model();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                own[i] = 0; dead[i] = 0; held[i] = 0; last[i] = 2;
            end else if (dead[i] > 0) begin
                dead[i]--;
                if (dead[i] == 0) begin own[i] = pick(last[i]); held[i] = 0; end
            end else if (own[i] == 0) begin
                own[i] = pick(last[i]); held[i] = 0;
            end else begin
                logic mine, oth;
                mine = own[i] == 1 ? req_a : req_b;
                oth = own[i] == 1 ? req_b : req_a;
                if (!mine || (mh[i] != 0 && oth && held[i] == mh[i] - 1)) begin
                    last[i] = own[i]; own[i] = 0; dead[i] = tc[i];
                end else held[i] = (held[i] + 1) % 256;
            end
        end
    endtask

    task automatic chk(string tag, int i, logic obs, logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s dut%0d cycle %0d observed %b expected %b", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        step_model();
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            chk("gnt_a", i, ga[i], own[i] == 1);
            chk("gnt_b", i, gb[i], own[i] == 2);
            chk("g1_n", i, e1[i], own[i] != 1);
            chk("g2_n", i, e2[i], own[i] != 2);
            chk("busy", i, bz[i], own[i] != 0 || dead[i] > 0);
            chk("mutex", i, e1[i] | e2[i], 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin own[i] = 0; dead[i] = 0; held[i] = 0; last[i] = 2; end
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
        repeat (2) cyc_step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_gnt_a", i, ga[i], 1'b0);
            chk("rst_gnt_b", i, gb[i], 1'b0);
            chk("rst_g1_n", i, e1[i], 1'b1);
            chk("rst_g2_n", i, e2[i], 1'b1);
            chk("rst_busy", i, bz[i], 1'b0);
        end
        reset = 1'b0;
        cyc_step();
        for (int i = 0; i < 3; i++) chk("first_tie", i, ga[i], 1'b1);
        repeat (30) cyc_step();
        chk("no_preempt", 2, ga[2], 1'b1);
        req_a = 1'b0; req_b = 1'b0;
        repeat (5) cyc_step();
        for (int i = 0; i < 3; i++) chk("idle", i, bz[i], 1'b0);
        req_b = 1'b1;
        cyc_step();
        for (int i = 0; i < 3; i++) chk("b_latency", i, gb[i], 1'b1);
        repeat (7) cyc_step();
        req_b = 1'b0;
        repeat (5) cyc_step();
        req_a = 1'b1; req_b = 1'b1;
        repeat (3) cyc_step();
        req_a = 1'b0; req_b = 1'b0;
        repeat (5) cyc_step();
        req_a = 1'b1;
        repeat (3) cyc_step();
        reset = 1'b1;
        cyc_step();
        for (int i = 0; i < 3; i++) chk("rst_midop", i, ga[i], 1'b0);
        reset = 1'b0; req_a = 1'b0;
        cyc_step();
        repeat (2000) begin
            if ($urandom % 8 == 0) req_a = ~req_a;
            if ($urandom % 8 == 0) req_b = ~req_b;
            reset = $urandom % 400 == 0;
            cyc_step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
